// File: rtl/ps2_rx_frame_if.sv
// PS/2 receiver bundle: raw pad inputs, the enable, and the received byte/status.
// The slave modport is the receiver. The master modport is the pad/consumer side.
interface ps2_rx_frame_if;
  logic       ps2d;
  logic       ps2c;
  logic       rx_en;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_tick;

  modport slave (
    input  ps2d, ps2c, rx_en,
    output dout, rx_done_tick, parity_err, frame_err, timeout_tick
  );

  modport master (
    output ps2d, ps2c, rx_en,
    input  dout, rx_done_tick, parity_err, frame_err, timeout_tick
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: sync, ps2c glitch filter, 11-bit frame shift-in.
// Optional inter-edge watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           reset,
  ps2_rx_frame_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;

  state_t                state_reg;
  logic [1:0]            ps2c_sync_reg;
  logic [1:0]            ps2d_sync_reg;
  logic [FILTER_LEN-1:0] filter_reg;
  logic [FILTER_LEN-1:0] filter_next;
  logic                  filtered_reg;
  logic                  filtered_next;
  logic                  fall_tick;
  logic [3:0]            n_reg;
  logic [10:0]           b_reg;
  logic [10:0]           b_next;
  logic [7:0]            dout_reg;
  logic                  rx_done_tick_reg;
  logic                  parity_err_reg;
  logic                  frame_err_reg;
  logic                  ps2c_s;
  logic                  ps2d_s;

  assign ps2c_s = ps2c_sync_reg[1];
  assign ps2d_s = ps2d_sync_reg[1];

  // Filtered clock only changes on a full run of identical samples
  assign filter_next = {ps2c_s, filter_reg[FILTER_LEN-1:1]};

  always_comb begin
    filtered_next = filtered_reg;
    if (&filter_next)
      filtered_next = 1'b1;
    else if (~|filter_next)
      filtered_next = 1'b0;
  end

  assign fall_tick = filtered_reg & ~filtered_next;
  assign b_next    = {ps2d_s, b_reg[10:1]};

`ifdef PS2_RX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_tick_reg;
  logic             timeout_hit;

  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)
      cnt_reg <= '0;
    else if (state_reg != DPS || fall_tick)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_reg + CNT_W'(1);
  end

  assign bus.timeout_tick = timeout_tick_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
  assign bus.timeout_tick   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      ps2c_sync_reg    <= 2'b11;
      ps2d_sync_reg    <= 2'b11;
      filter_reg       <= '0;
      filtered_reg     <= 1'b1;
      n_reg            <= '0;
      b_reg            <= '0;
      dout_reg         <= '0;
      rx_done_tick_reg <= 1'b0;
      parity_err_reg   <= 1'b0;
      frame_err_reg    <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      timeout_tick_reg <= 1'b0;
`endif
    end else begin
      ps2c_sync_reg    <= {ps2c_sync_reg[0], bus.ps2c};
      ps2d_sync_reg    <= {ps2d_sync_reg[0], bus.ps2d};
      filter_reg       <= filter_next;
      filtered_reg     <= filtered_next;
      rx_done_tick_reg <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      timeout_tick_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (fall_tick && bus.rx_en && !ps2d_s) begin
            b_reg     <= b_next;
            n_reg     <= 4'd9;
            state_reg <= DPS;
          end
        end
        DPS: begin
          if (fall_tick) begin
            b_reg <= b_next;
            if (n_reg == 4'd0) begin
              // Outputs are taken from the post-shift frame so they are valid in LOAD
              state_reg        <= LOAD;
              rx_done_tick_reg <= 1'b1;
              dout_reg         <= b_next[8:1];
              parity_err_reg   <= ~(^b_next[9:1]);
              frame_err_reg    <= ~b_next[10];
            end else begin
              n_reg <= n_reg - 4'd1;
            end
          end
`ifdef PS2_RX_TIMEOUT_EN
          else if (timeout_hit) begin
            state_reg        <= IDLE;
            n_reg            <= '0;
            timeout_tick_reg <= 1'b1;
          end
`endif
        end
        LOAD: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.dout         = dout_reg;
  assign bus.rx_done_tick = rx_done_tick_reg;
  assign bus.parity_err   = parity_err_reg;
  assign bus.frame_err    = frame_err_reg;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: frames, error flags, glitches, rx_en, reset, watchdog.
// PS/2 clock is time-scaled (80 clk period) so the run stays short.
module tb_ps2_rx_frame;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int HALF       = 40;

  logic clk;
  logic reset;
  int   cyc;
  int   check_count;
  int   pass_count;
  int   done_count;
  int   to_count;
  int   done_cyc;
  int   to_cyc;
  int   last_fall_cyc;
  logic [7:0] cap_dout;
  logic       cap_perr;
  logic       cap_ferr;

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_done_tick) begin
        done_count++;
        done_cyc = cyc;
        cap_dout = bus.dout;
        cap_perr = bus.parity_err;
        cap_ferr = bus.frame_err;
        $display("rx frame: dout=%02h parity_err=%b frame_err=%b @cyc %0d",
                 bus.dout, bus.parity_err, bus.frame_err, cyc);
      end
      if (bus.timeout_tick) begin
        to_count++;
        to_cyc = cyc;
        $display("rx timeout @cyc %0d", cyc);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of {stop, par, data, start}; optional glitch in a high phase
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int nbits, input bit drop_en, input int glitch_bit);
    logic [10:0] f;
    f = {stop, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2d = f[i];
      if (i == glitch_bit) begin
        wait_cyc(10);
        bus.ps2c = 1'b0;
        wait_cyc(3);
        bus.ps2c = 1'b1;
        wait_cyc(HALF - 13);
      end else begin
        wait_cyc(HALF);
      end
      bus.ps2c = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(HALF);
      bus.ps2c = 1'b1;
      if (drop_en && i == 0) bus.rx_en = 1'b0;
    end
    bus.ps2d = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_cyc(5);
    check_count++; if (bus.dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", bus.dout); else pass_count++;
    check_count++; if (bus.rx_done_tick !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.rx_done_tick); else pass_count++;
    check_count++; if (bus.parity_err !== 1'b0) $display("FAIL reset_perr: got %b expected 0", bus.parity_err); else pass_count++;
    check_count++; if (bus.frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", bus.frame_err); else pass_count++;
    check_count++; if (bus.timeout_tick !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", bus.timeout_tick); else pass_count++;
    reset = 1'b0;
    wait_cyc(20);
  endtask

  task automatic test_basic_frame;
    int d0;
    d0 = done_count;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, -1);
    check_count++; if (done_count - d0 !== 1) $display("FAIL basic_ticks: got %0d expected 1", done_count - d0); else pass_count++;
    check_count++; if (cap_dout !== 8'h1C) $display("FAIL basic_dout: got %h expected 1c", cap_dout); else pass_count++;
    check_count++; if (cap_perr !== 1'b0) $display("FAIL basic_perr: got %b expected 0", cap_perr); else pass_count++;
    check_count++; if (cap_ferr !== 1'b0) $display("FAIL basic_ferr: got %b expected 0", cap_ferr); else pass_count++;
    check_count++; if (done_cyc - last_fall_cyc !== FILTER_LEN + 2) $display("FAIL basic_latency: got %0d expected %0d", done_cyc - last_fall_cyc, FILTER_LEN + 2); else pass_count++;
    check_count++; if (bus.dout !== 8'h1C) $display("FAIL basic_hold: got %h expected 1c", bus.dout); else pass_count++;
  endtask

  task automatic test_parity;
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, -1);
    check_count++; if (cap_dout !== 8'h1C) $display("FAIL parity_bad_dout: got %h expected 1c", cap_dout); else pass_count++;
    check_count++; if (cap_perr !== 1'b1) $display("FAIL parity_bad_perr: got %b expected 1", cap_perr); else pass_count++;
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0, -1);
    check_count++; if (cap_dout !== 8'hF0) $display("FAIL parity_good_dout: got %h expected f0", cap_dout); else pass_count++;
    check_count++; if (cap_perr !== 1'b0) $display("FAIL parity_good_perr: got %b expected 0", cap_perr); else pass_count++;
  endtask

  task automatic test_framing;
    send_frame(8'h5A, 1'b1, 1'b0, 11, 1'b0, -1);
    check_count++; if (cap_dout !== 8'h5A) $display("FAIL frame_bad_dout: got %h expected 5a", cap_dout); else pass_count++;
    check_count++; if (cap_ferr !== 1'b1) $display("FAIL frame_bad_ferr: got %b expected 1", cap_ferr); else pass_count++;
    check_count++; if (cap_perr !== 1'b0) $display("FAIL frame_bad_perr: got %b expected 0", cap_perr); else pass_count++;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, -1);
    check_count++; if (cap_ferr !== 1'b0) $display("FAIL frame_clear_ferr: got %b expected 0", cap_ferr); else pass_count++;
  endtask

  task automatic test_glitch;
    int d0;
    d0 = done_count;
    bus.ps2c = 1'b0;
    wait_cyc(3);
    bus.ps2c = 1'b1;
    wait_cyc(50);
    check_count++; if (done_count !== d0) $display("FAIL glitch_idle: got %0d ticks expected 0", done_count - d0); else pass_count++;
    send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0, 4);
    check_count++; if (done_count - d0 !== 1) $display("FAIL glitch_ticks: got %0d expected 1", done_count - d0); else pass_count++;
    check_count++; if (cap_dout !== 8'h29) $display("FAIL glitch_dout: got %h expected 29", cap_dout); else pass_count++;
    check_count++; if (cap_perr !== 1'b0 || cap_ferr !== 1'b0) $display("FAIL glitch_flags: got %b%b expected 00", cap_perr, cap_ferr); else pass_count++;
  endtask

  task automatic test_rx_en_and_reset;
    int d0;
    d0 = done_count;
    bus.rx_en = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, -1);
    check_count++; if (done_count !== d0) $display("FAIL rxen_off: got %0d ticks expected 0", done_count - d0); else pass_count++;
    bus.rx_en = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b1, -1);
    check_count++; if (done_count - d0 !== 1) $display("FAIL rxen_drop_ticks: got %0d expected 1", done_count - d0); else pass_count++;
    check_count++; if (cap_dout !== 8'h5A) $display("FAIL rxen_drop_dout: got %h expected 5a", cap_dout); else pass_count++;
    bus.rx_en = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b0, -1);
    reset = 1'b1;
    wait_cyc(1);
    check_count++; if (bus.dout !== 8'h00) $display("FAIL midreset_dout: got %h expected 00", bus.dout); else pass_count++;
    check_count++; if (bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) $display("FAIL midreset_flags: got %b%b expected 00", bus.parity_err, bus.frame_err); else pass_count++;
    check_count++; if (bus.rx_done_tick !== 1'b0 || bus.timeout_tick !== 1'b0) $display("FAIL midreset_ticks: got %b%b expected 00", bus.rx_done_tick, bus.timeout_tick); else pass_count++;
    reset = 1'b0;
    wait_cyc(20);
    d0 = done_count;
    send_frame(8'h76, 1'b0, 1'b1, 11, 1'b0, -1);
    check_count++; if (done_count - d0 !== 1) $display("FAIL postreset_ticks: got %0d expected 1", done_count - d0); else pass_count++;
    check_count++; if (cap_dout !== 8'h76) $display("FAIL postreset_dout: got %h expected 76", cap_dout); else pass_count++;
  endtask

  task automatic test_timeout;
    int d0;
    int t0;
    int lf;
    d0 = done_count;
    t0 = to_count;
    send_frame(8'h12, 1'b1, 1'b1, 4, 1'b0, -1);
    lf = last_fall_cyc;
    for (int k = 0; k < 1500 && to_count == t0; k++) wait_cyc(1);
    wait_cyc(20);
    check_count++; if (done_count !== d0) $display("FAIL trunc_no_done: got %0d ticks expected 0", done_count - d0); else pass_count++;
    check_count++; if (bus.dout !== 8'h76) $display("FAIL trunc_dout_hold: got %h expected 76", bus.dout); else pass_count++;
`ifdef PS2_RX_TIMEOUT_EN
    check_count++; if (to_count - t0 !== 1) $display("FAIL timeout_ticks: got %0d expected 1", to_count - t0); else pass_count++;
    check_count++; if (to_cyc - lf !== TIMEOUT + FILTER_LEN + 2) $display("FAIL timeout_latency: got %0d expected %0d", to_cyc - lf, TIMEOUT + FILTER_LEN + 2); else pass_count++;
`else
    check_count++; if (to_count !== t0) $display("FAIL timeout_disabled: got %0d ticks expected 0", to_count - t0); else pass_count++;
    check_count++; if (lf <= 0) $display("FAIL trunc_sent: got last fall %0d expected >0", lf); else pass_count++;
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(20);
`endif
    d0 = done_count;
    send_frame(8'h12, 1'b1, 1'b1, 11, 1'b0, -1);
    check_count++; if (done_count - d0 !== 1) $display("FAIL after_trunc_ticks: got %0d expected 1", done_count - d0); else pass_count++;
    check_count++; if (cap_dout !== 8'h12) $display("FAIL after_trunc_dout: got %h expected 12", cap_dout); else pass_count++;
    check_count++; if (cap_perr !== 1'b0) $display("FAIL after_trunc_perr: got %b expected 0", cap_perr); else pass_count++;
  endtask

  initial begin
    cyc = 0;
    check_count = 0;
    pass_count = 0;
    done_count = 0;
    to_count = 0;
    done_cyc = 0;
    to_cyc = 0;
    last_fall_cyc = 0;
    cap_dout = '0;
    cap_perr = 1'b0;
    cap_ferr = 1'b0;
    bus.ps2c = 1'b1;
    bus.ps2d = 1'b1;
    bus.rx_en = 1'b1;
    reset = 1'b1;
    test_reset();
    test_basic_frame();
    test_parity();
    test_framing();
    test_glitch();
    test_rx_en_and_reset();
    test_timeout();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
